timer_ctrl: RTL

//  Control stage directly upstream of the kitchen-timer BCD down-counter chain (MM:SS).
//  - Turns button presses into set pulses.
//  - Generates the 1 s run tick into the seconds-LSD borrow input.
//  - Clears the chain.
//  - Detects expiry via the chain's all-zero flag and drives a time-limited buzzer.

---
 rtl/timer_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/timer_ctrl.sv
// Kitchen-timer control stage: button events, 1 s run tick, chain clear, expiry alarm with buzzer.
// Latency: a button press acts on the outputs at the 3rd clk edge after it rises; all outputs are registered.
// Backpressure: none; the chain accepts one pulse per cycle, and zero is ignored while a pulse is settling.
module timer_ctrl #(
    parameter int TICK_DIV  = 50000000,
    parameter int BEEP_DIV  = 25000,
    parameter int ALARM_SEC = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_start,
    input  logic btn_min,
    input  logic btn_sec,
    input  logic btn_clr,
    input  logic zero,
    output logic sec_bin,
    output logic min_bin,
    output logic cnt_clr,
    output logic buzzer,
    output logic run_led,
    output logic alarm_led
);

    // Counter widths follow the dividers; a divider of 1 still gets a 1-bit counter.
    localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int BW = (BEEP_DIV  > 1) ? $clog2(BEEP_DIV)  : 1;
    localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;

    localparam logic [PW-1:0] PS_LAST   = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_DIV - 1);
    localparam logic [AW-1:0] AC_LAST   = AW'(ALARM_SEC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Button vector order: {clr, start, min, sec} -- also the priority order, high to low.
    logic [3:0] btn_raw;
    logic [3:0] btn_s1;
    logic [3:0] btn_s2;
    logic [3:0] btn_d;
    logic [3:0] rise;

    logic ev_clr;
    logic ev_start;
    logic ev_min;
    logic ev_sec;
    logic ev_any;

    logic [PW-1:0] prescaler;
    logic [BW-1:0] beep_cnt;
    logic [AW-1:0] alarm_cnt;

    logic tick;
    logic beep_wrap;
    logic alarm_done;
    logic zero_stale;
    logic zero_valid;

    logic sec_bin_nxt;
    logic min_bin_nxt;
    logic cnt_clr_nxt;
    logic buzzer_nxt;
    logic run_led_nxt;
    logic alarm_led_nxt;

    assign btn_raw = {btn_clr, btn_start, btn_min, btn_sec};

    // Two-flop synchroniser plus one delay stage for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            btn_d  <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            btn_d  <= btn_s2;
        end
    end

    // One event per press; only the highest-priority simultaneous event survives.
    assign rise     = btn_s2 & ~btn_d;
    assign ev_clr   = rise[3];
    assign ev_start = rise[2] & ~rise[3];
    assign ev_min   = rise[1] & ~(|rise[3:2]);
    assign ev_sec   = rise[0] & ~(|rise[3:1]);
    assign ev_any   = |rise;

    assign tick       = (prescaler == PS_LAST);
    assign beep_wrap  = (beep_cnt == BEEP_LAST);
    assign alarm_done = tick && (alarm_cnt == AC_LAST);

    // While a pulse to the chain is in flight, zero still shows the pre-pulse count.
    assign zero_stale = sec_bin | min_bin | cnt_clr;
    assign zero_valid = zero & ~zero_stale;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: clear first, then expiry, then start/pause.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ev_start && !zero && !zero_stale) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (ev_clr) begin
                    state_nxt = IDLE;
                end else if (zero_valid) begin
                    state_nxt = ALARM;
                end else if (ev_start) begin
                    state_nxt = PAUSE;
                end
            end
            PAUSE: begin
                if (ev_clr) begin
                    state_nxt = IDLE;
                end else if (ev_start) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                // Any button silences the alarm and is consumed doing so.
                if (ev_any || alarm_done) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // Output decode: next values of the registered outputs.
    always_comb begin
        sec_bin_nxt = 1'b0;
        min_bin_nxt = 1'b0;
        cnt_clr_nxt = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr_nxt = ev_clr;
                min_bin_nxt = ev_min;
                sec_bin_nxt = ev_sec;
            end
            RUN: begin
                cnt_clr_nxt = ev_clr;
                // A tick coinciding with a pause still counts the elapsed second.
                sec_bin_nxt = tick && !ev_clr && !zero_valid;
            end
            PAUSE: begin
                cnt_clr_nxt = ev_clr;
            end
            default: begin
            end
        endcase
        buzzer_nxt    = (state == ALARM && state_nxt == ALARM) ? (beep_wrap ? ~buzzer : buzzer) : 1'b0;
        run_led_nxt   = (state_nxt == RUN);
        alarm_led_nxt = (state_nxt == ALARM);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sec_bin   <= 1'b0;
            min_bin   <= 1'b0;
            cnt_clr   <= 1'b0;
            buzzer    <= 1'b0;
            run_led   <= 1'b0;
            alarm_led <= 1'b0;
        end else begin
            sec_bin   <= sec_bin_nxt;
            min_bin   <= min_bin_nxt;
            cnt_clr   <= cnt_clr_nxt;
            buzzer    <= buzzer_nxt;
            run_led   <= run_led_nxt;
            alarm_led <= alarm_led_nxt;
        end
    end

    // Prescaler counts RUN and ALARM cycles, holds in PAUSE, restarts on IDLE and on alarm entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
        end else if (state_nxt == IDLE || (state_nxt == ALARM && state != ALARM)) begin
            prescaler <= '0;
        end else if (state == RUN || state == ALARM) begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
        end
    end

    // Tone half-period and alarm-duration counters, live only while the alarm persists.
    always_ff @(posedge clk) begin
        if (reset) begin
            beep_cnt  <= '0;
            alarm_cnt <= '0;
        end else if (state == ALARM && state_nxt == ALARM) begin
            beep_cnt <= beep_wrap ? '0 : beep_cnt + 1'b1;
            if (tick) begin
                alarm_cnt <= alarm_cnt + 1'b1;
            end
        end else begin
            beep_cnt  <= '0;
            alarm_cnt <= '0;
        end
    end

endmodule
